wdt_window: RTL and testbench
=============================

# wdt_window

Parametrised windowed watchdog for the microcontroller. It succeeds the fixed PC-stall watchdog and adds:
- a configurable prescaler and timeout;
- a keyed software kick;
- an optional early-kick window;
- an early-warning flag;
- a stretched reset pulse;
- a sticky fault cause.

`o_reset` drives the MCU watchdog-reset input; `i_pc` taps the MCU program counter.

## Interface
- `CNT_W`, 16, timeout counter width
- `PC_W`, 8, program counter width
- `PRESC_W`, 8, prescaler width
- `RST_PULSE`, 4, `o_reset` high time in clocks (≥1)
- `KICK_KEY`, 8'hA5, required kick key
- `clk` in 1: single clock; all logic on its rising edge
- `rst` in 1: synchronous, active-high reset
- `i_pc` in `PC_W`: MCU program counter
- `i_cfg_we` in 1: configuration write strobe
- `i_cfg_mode` in 2: 00 off, 01 timeout, 10 window, 11 pc-stall
- `i_cfg_timeout` in `CNT_W`: timeout T in ticks (0 illegal)
- `i_cfg_window` in `CNT_W`: window-open W in ticks
- `i_cfg_presc` in `PRESC_W`: P; one tick every P+1 clocks
- `i_kick_valid` in 1: software kick strobe
- `i_kick_key` in 8: kick key
- `o_reset` out 1: watchdog reset pulse
- `o_warn` out 1: count ≥ T>>1 while RUN
- `o_count` out `CNT_W`: current tick count
- `o_cause` out 2: last fault, 00 none, 01 timeout, 10 early, 11 bad key
- `o_lock` out 1: configuration locked
- `o_fire_cnt` out 4: saturating count of fires

## Operation
- **State IDLE** (after reset):
  - `i_cfg_we` with mode≠00 and T≠0 latches mode, T, W and P.
  - It clears the count and prescaler, sets `o_lock`, and moves to RUN.
  - Any other write is ignored.
- **State RUN**:
  - The prescaler counts 0..P; at P it wraps and issues a tick; each tick increments the count.
  - A tick when count==T-1 fires with cause 01. `o_count` never reaches T.
- **Valid kick** (`i_kick_valid`, key==`KICK_KEY`): clears count and prescaler.
  - In window mode, a valid kick with count<W fires with cause 10 instead.
- **Bad-key kick** (any mode except pc-stall auto-kicks): fires with cause 11.
- **pc-stall mode**: `i_pc` is registered each clock. A change from the registered value acts as a valid kick. Explicit kicks are still honoured; no window check applies.
- **Fire**: enters FIRE, writes `o_cause`, and increments `o_fire_cnt` (saturates at 15).
- **State FIRE**:
  - `o_reset` is high for exactly `RST_PULSE` clocks.
  - Kicks, PC changes and ticks are ignored.
  - It then returns to RUN with count and prescaler at 0, keeping config and lock.
- **Config writes**: ignored in RUN and FIRE. The lock clears only on `rst`.
- **Simultaneous events**:
  - A valid kick on the same edge as the T-th tick wins: no fire.
  - A bad key on the same edge as the timeout gives cause 11.
  - An early kick on the same edge as the timeout gives cause 10.
- **`o_warn`**: combinational from state and count; 0 outside RUN.

## Timing
- **Reset values**: all outputs 0, state IDLE.
- **Reset mid-FIRE**: `o_reset` is 0 after the `rst` edge.
- **Timeout latency**: a kick or RUN entry at edge k fires at edge k+T·(P+1). `o_reset` is high after that edge through edge k+T·(P+1)+`RST_PULSE`.
- **Kick/key faults**: `o_reset` rises after the edge that samples the offending kick (one-clock latency).
- **`o_cause` and `o_fire_cnt`**: update on the same edge on which `o_reset` rises.
- **pc-stall**: the first PC change is detected one clock after `i_pc` changes (registered compare).

## Structure
- **Package `wdt_pkg`**: state enum (IDLE, RUN, FIRE), mode codes, cause codes.
- **Sub-module `wdt_prescaler`**: `PRESC_W` counter with sync clear and tick output.
- **Top**: holds the FSM, count, compare logic, pulse stretcher, cause and fire counter.

## Test plan
- **Timeout**: mode 01, T=10, P=1, configured at edge 0, no kicks -> `o_reset` high edges 20–23; `o_cause`=01; `o_fire_cnt`=1; next fire at edge 44.
- **Window**: mode 10, T=100, W=40, P=0.
  - Kick at count 20 -> `o_reset` next clock, cause 10.
  - After recovery, kick at count 50 -> count 0, no reset.
- **Bad key**: mode 01, kick with key 8'h00 -> `o_reset` next clock, cause 11, `o_fire_cnt` increments.
- **pc-stall**: mode 11, T=8, P=0.
  - `i_pc` increments every 5 clocks -> never fires.
  - Freeze PC -> fire 8 clocks after the detected last change, cause 01.
- **Boundary**:
  - Valid kick on the exact T-th tick -> no reset.
  - Config write in RUN -> ignored, `o_lock`=1.
  - T=0 in IDLE -> stays IDLE.
  - `rst` mid-FIRE -> all outputs 0 next edge.
- **Warning**: T=10, P=0 -> `o_warn` rises at count 5, drops on kick; 16 forced fires -> `o_fire_cnt` holds 15.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types for the windowed watchdog: FSM states, configuration mode
// codes and fault cause codes.
package wdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIRE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_TIMEOUT = 2'b01,
    MODE_WINDOW  = 2'b10,
    MODE_PCSTALL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_TIMEOUT = 2'b01,
    CAUSE_EARLY   = 2'b10,
    CAUSE_BADKEY  = 2'b11
  } cause_e;

  localparam int unsigned FIRE_CNT_W = 4;

endpackage

// File: rtl/wdt_prescaler.sv
// Tick prescaler for the watchdog.
//   clk, rst  : clock, synchronous active-high reset
//   i_clr     : synchronous clear (priority over counting)
//   i_en      : count enable
//   i_presc   : terminal value P; one tick every P+1 enabled clocks
//   o_tick    : high in the cycle whose edge wraps the counter
module wdt_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [PRESC_W-1:0] i_presc,
  output logic               o_tick
);

  logic [PRESC_W-1:0] cnt_d, cnt_q;
  logic               wrap;

  assign wrap   = (cnt_q == i_presc);
  assign o_tick = i_en && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = wrap ? '0 : cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wdt_window.sv
// Windowed watchdog with keyed kick, optional early-kick window, PC-stall
// auto-kick, early warning, stretched reset pulse and sticky fault cause.
//   clk, rst        : clock, synchronous active-high reset
//   i_pc            : MCU program counter (auto-kick source in pc-stall mode)
//   i_cfg_*         : configuration, accepted once in IDLE on i_cfg_we
//   i_kick_valid/key: software kick strobe and key
//   o_reset         : watchdog reset pulse, RST_PULSE clocks wide
//   o_warn          : count has reached half the timeout while running
//   o_count         : current tick count
//   o_cause         : last fault cause
//   o_lock          : configuration locked (cleared only by rst)
//   o_fire_cnt      : saturating fire counter
module wdt_window
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned PC_W      = 8,
  parameter int unsigned PRESC_W   = 8,
  parameter int unsigned RST_PULSE = 4,
  parameter logic [7:0]  KICK_KEY  = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    i_pc,
  input  logic               i_cfg_we,
  input  logic [1:0]         i_cfg_mode,
  input  logic [CNT_W-1:0]   i_cfg_timeout,
  input  logic [CNT_W-1:0]   i_cfg_window,
  input  logic [PRESC_W-1:0] i_cfg_presc,
  input  logic               i_kick_valid,
  input  logic [7:0]         i_kick_key,
  output logic               o_reset,
  output logic               o_warn,
  output logic [CNT_W-1:0]   o_count,
  output logic [1:0]         o_cause,
  output logic               o_lock,
  output logic [3:0]         o_fire_cnt
);

  localparam int unsigned PULSE_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE - 1);

  state_e                  state_d, state_q;
  mode_e                   mode_d, mode_q;
  cause_e                  cause_d, cause_q;
  logic [CNT_W-1:0]        timeout_d, timeout_q;
  logic [CNT_W-1:0]        window_d, window_q;
  logic [PRESC_W-1:0]      presc_d, presc_q;
  logic [CNT_W-1:0]        count_d, count_q;
  logic [PULSE_W-1:0]      pulse_d, pulse_q;
  logic                    reset_d, reset_q;
  logic                    lock_d, lock_q;
  logic [FIRE_CNT_W-1:0]   fire_cnt_d, fire_cnt_q;
  logic [PC_W-1:0]         pc_q;

  logic   key_ok, key_bad, pc_kick, tick, presc_clr, fire;
  cause_e fire_cause;

  assign key_ok  = i_kick_valid && (i_kick_key == KICK_KEY);
  assign key_bad = i_kick_valid && (i_kick_key != KICK_KEY);
  assign pc_kick = (mode_q == MODE_PCSTALL) && (i_pc != pc_q);

  // Prescaler is held at 0 outside RUN, so both RUN entry and FIRE exit
  // restart the tick phase from zero.
  assign presc_clr = (state_q != ST_RUN) || key_ok || pc_kick;

  wdt_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (presc_clr),
    .i_en    (state_q == ST_RUN),
    .i_presc (presc_q),
    .o_tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cause_d    = cause_q;
    timeout_d  = timeout_q;
    window_d   = window_q;
    presc_d    = presc_q;
    count_d    = count_q;
    pulse_d    = pulse_q;
    reset_d    = reset_q;
    lock_d     = lock_q;
    fire_cnt_d = fire_cnt_q;
    fire       = 1'b0;
    fire_cause = CAUSE_NONE;

    case (state_q)
      ST_IDLE: begin
        if (i_cfg_we && (i_cfg_mode != MODE_OFF) && (i_cfg_timeout != '0)) begin
          mode_d    = mode_e'(i_cfg_mode);
          timeout_d = i_cfg_timeout;
          window_d  = i_cfg_window;
          presc_d   = i_cfg_presc;
          count_d   = '0;
          lock_d    = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        // Kick faults outrank a simultaneous timeout; a good kick beats it.
        if (key_bad) begin
          fire       = 1'b1;
          fire_cause = CAUSE_BADKEY;
        end else if (key_ok && (mode_q == MODE_WINDOW) && (count_q < window_q)) begin
          fire       = 1'b1;
          fire_cause = CAUSE_EARLY;
        end else if (key_ok || pc_kick) begin
          count_d = '0;
        end else if (tick) begin
          if (count_q == timeout_q - CNT_W'(1)) begin
            fire       = 1'b1;
            fire_cause = CAUSE_TIMEOUT;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_FIRE: begin
        if (pulse_q == '0) begin
          state_d = ST_RUN;
          reset_d = 1'b0;
          count_d = '0;
        end else begin
          pulse_d = pulse_q - PULSE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fire) begin
      state_d = ST_FIRE;
      reset_d = 1'b1;
      pulse_d = PULSE_LAST;
      cause_d = fire_cause;
      count_d = '0;
      if (fire_cnt_q != '1) begin
        fire_cnt_d = fire_cnt_q + FIRE_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_OFF;
      cause_q    <= CAUSE_NONE;
      timeout_q  <= '0;
      window_q   <= '0;
      presc_q    <= '0;
      count_q    <= '0;
      pulse_q    <= '0;
      reset_q    <= 1'b0;
      lock_q     <= 1'b0;
      fire_cnt_q <= '0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cause_q    <= cause_d;
      timeout_q  <= timeout_d;
      window_q   <= window_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      pulse_q    <= pulse_d;
      reset_q    <= reset_d;
      lock_q     <= lock_d;
      fire_cnt_q <= fire_cnt_d;
      pc_q       <= i_pc;
    end
  end

  assign o_reset    = reset_q;
  assign o_warn     = (state_q == ST_RUN) && (count_q >= (timeout_q >> 1));
  assign o_count    = count_q;
  assign o_cause    = cause_q;
  assign o_lock     = lock_q;
  assign o_fire_cnt = fire_cnt_q;

endmodule

// File: tb/tb_wdt_window.sv
module tb_wdt_window;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_pc = '0;
  logic        i_cfg_we = 1'b0;
  logic [1:0]  i_cfg_mode = '0;
  logic [15:0] i_cfg_timeout = '0;
  logic [15:0] i_cfg_window = '0;
  logic [7:0]  i_cfg_presc = '0;
  logic        i_kick_valid = 1'b0;
  logic [7:0]  i_kick_key = '0;
  logic        o_reset, o_warn, o_lock;
  logic [15:0] o_count;
  logic [1:0]  o_cause;
  logic [3:0]  o_fire_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wdt_window #(
    .CNT_W     (16),
    .PC_W      (8),
    .PRESC_W   (8),
    .RST_PULSE (4),
    .KICK_KEY  (8'hA5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pc          (i_pc),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_mode    (i_cfg_mode),
    .i_cfg_timeout (i_cfg_timeout),
    .i_cfg_window  (i_cfg_window),
    .i_cfg_presc   (i_cfg_presc),
    .i_kick_valid  (i_kick_valid),
    .i_kick_key    (i_kick_key),
    .o_reset       (o_reset),
    .o_warn        (o_warn),
    .o_count       (o_count),
    .o_cause       (o_cause),
    .o_lock        (o_lock),
    .o_fire_cnt    (o_fire_cnt)
  );

  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    i_kick_valid = 1'b0;
    i_cfg_we = 1'b0;
    i_pc = '0;
    step(2);
    rst = 1'b0;
  endtask

  // The configuration write is sampled by the edge inside this task (edge 0).
  task automatic configure(input logic [1:0] mode, input logic [15:0] t,
                           input logic [15:0] w, input logic [7:0] p);
    i_cfg_mode = mode;
    i_cfg_timeout = t;
    i_cfg_window = w;
    i_cfg_presc = p;
    i_cfg_we = 1'b1;
    step(1);
    i_cfg_we = 1'b0;
  endtask

  task automatic kick(input logic [7:0] key);
    i_kick_valid = 1'b1;
    i_kick_key = key;
    step(1);
    i_kick_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({o_reset, o_warn, o_count, o_cause, o_lock, o_fire_cnt} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rst=%0b warn=%0b cnt=%0d cause=%0d lock=%0b fires=%0d expected all 0",
               o_reset, o_warn, o_count, o_cause, o_lock, o_fire_cnt);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    configure(2'b01, 16'd10, 16'd0, 8'd1);
    n_cmp++;
    if (o_lock !== 1'b1) begin n_err++; $display("FAIL timeout_lock: got %0b expected 1", o_lock); end
    step(19);
    n_cmp++;
    if (o_count !== 16'd9 || o_reset !== 1'b0) begin
      n_err++; $display("FAIL timeout_edge19: got cnt=%0d rst=%0b expected cnt=9 rst=0", o_count, o_reset);
    end
    step(1);
    n_cmp++;
    if (o_reset !== 1'b1 || o_cause !== 2'b01 || o_fire_cnt !== 4'd1) begin
      n_err++; $display("FAIL timeout_edge20: got rst=%0b cause=%0d fires=%0d expected 1/1/1", o_reset, o_cause, o_fire_cnt);
    end
    step(3);
    n_cmp++;
    if (o_reset !== 1'b1) begin n_err++; $display("FAIL timeout_edge23: got rst=%0b expected 1", o_reset); end
    step(1);
    n_cmp++;
    if (o_reset !== 1'b0 || o_count !== 16'd0) begin
      n_err++; $display("FAIL timeout_edge24: got rst=%0b cnt=%0d expected 0/0", o_reset, o_count);
    end
    step(19);
    n_cmp++;
    if (o_reset !== 1'b0) begin n_err++; $display("FAIL timeout_edge43: got rst=%0b expected 0", o_reset); end
    step(1);
    n_cmp++;
    if (o_reset !== 1'b1 || o_fire_cnt !== 4'd2) begin
      n_err++; $display("FAIL timeout_edge44: got rst=%0b fires=%0d expected 1/2", o_reset, o_fire_cnt);
    end
  endtask

  task automatic test_window();
    apply_reset();
    configure(2'b10, 16'd100, 16'd40, 8'd0);
    step(20);
    n_cmp++;
    if (o_count !== 16'd20) begin n_err++; $display("FAIL window_count20: got %0d expected 20", o_count); end
    kick(8'hA5);
    n_cmp++;
    if (o_reset !== 1'b1 || o_cause !== 2'b10) begin
      n_err++; $display("FAIL window_early: got rst=%0b cause=%0d expected 1/2", o_reset, o_cause);
    end
    step(3);
    n_cmp++;
    if (o_reset !== 1'b1) begin n_err++; $display("FAIL window_pulse_end: got rst=%0b expected 1", o_reset); end
    step(1);
    n_cmp++;
    if (o_reset !== 1'b0 || o_count !== 16'd0) begin
      n_err++; $display("FAIL window_recover: got rst=%0b cnt=%0d expected 0/0", o_reset, o_count);
    end
    step(50);
    n_cmp++;
    if (o_count !== 16'd50) begin n_err++; $display("FAIL window_count50: got %0d expected 50", o_count); end
    kick(8'hA5);
    n_cmp++;
    if (o_reset !== 1'b0 || o_count !== 16'd0 || o_fire_cnt !== 4'd1 || o_cause !== 2'b10) begin
      n_err++; $display("FAIL window_late_kick: got rst=%0b cnt=%0d fires=%0d cause=%0d expected 0/0/1/2",
                        o_reset, o_count, o_fire_cnt, o_cause);
    end
  endtask

  task automatic test_bad_key();
    apply_reset();
    configure(2'b01, 16'd100, 16'd0, 8'd0);
    step(5);
    kick(8'h00);
    n_cmp++;
    if (o_reset !== 1'b1 || o_cause !== 2'b11 || o_fire_cnt !== 4'd1) begin
      n_err++; $display("FAIL bad_key: got rst=%0b cause=%0d fires=%0d expected 1/3/1", o_reset, o_cause, o_fire_cnt);
    end
    n_cmp++;
    if (o_warn !== 1'b0) begin n_err++; $display("FAIL bad_key_warn_in_fire: got %0b expected 0", o_warn); end
  endtask

  task automatic test_pc_stall();
    logic seen_reset;
    apply_reset();
    configure(2'b11, 16'd8, 16'd0, 8'd0);
    seen_reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) i_pc = i_pc + 8'd1;
      step(1);
      if (o_reset !== 1'b0) seen_reset = 1'b1;
    end
    n_cmp++;
    if (seen_reset !== 1'b0) begin n_err++; $display("FAIL pc_running: got reset=1 expected 0"); end
    // Last change detected at edge 36; 8 ticks later (edge 44) it fires.
    step(3);
    n_cmp++;
    if (o_reset !== 1'b0 || o_count !== 16'd7) begin
      n_err++; $display("FAIL pc_before_fire: got rst=%0b cnt=%0d expected 0/7", o_reset, o_count);
    end
    step(1);
    n_cmp++;
    if (o_reset !== 1'b1 || o_cause !== 2'b01) begin
      n_err++; $display("FAIL pc_stall_fire: got rst=%0b cause=%0d expected 1/1", o_reset, o_cause);
    end
  endtask

  task automatic test_boundary();
    // Valid kick on the timeout tick
    apply_reset();
    configure(2'b01, 16'd10, 16'd0, 8'd0);
    step(9);
    kick(8'hA5);
    n_cmp++;
    if (o_reset !== 1'b0 || o_count !== 16'd0) begin
      n_err++; $display("FAIL kick_on_tick: got rst=%0b cnt=%0d expected 0/0", o_reset, o_count);
    end
    // Bad key on the timeout tick
    step(9);
    kick(8'h5A);
    n_cmp++;
    if (o_reset !== 1'b1 || o_cause !== 2'b11) begin
      n_err++; $display("FAIL badkey_on_tick: got rst=%0b cause=%0d expected 1/3", o_reset, o_cause);
    end
    // Early kick on the timeout tick
    apply_reset();
    configure(2'b10, 16'd10, 16'd20, 8'd0);
    step(9);
    kick(8'hA5);
    n_cmp++;
    if (o_reset !== 1'b1 || o_cause !== 2'b10) begin
      n_err++; $display("FAIL early_on_tick: got rst=%0b cause=%0d expected 1/2", o_reset, o_cause);
    end
    // Config write in RUN ignored
    apply_reset();
    configure(2'b01, 16'd100, 16'd0, 8'd0);
    configure(2'b10, 16'd3, 16'd50, 8'd0);
    step(5);
    n_cmp++;
    if (o_reset !== 1'b0 || o_lock !== 1'b1 || o_count !== 16'd6) begin
      n_err++; $display("FAIL cfg_in_run: got rst=%0b lock=%0b cnt=%0d expected 0/1/6", o_reset, o_lock, o_count);
    end
    kick(8'hA5);
    n_cmp++;
    if (o_reset !== 1'b0 || o_count !== 16'd0) begin
      n_err++; $display("FAIL cfg_in_run_mode: got rst=%0b cnt=%0d expected 0/0", o_reset, o_count);
    end
    // T=0 and mode off in IDLE ignored
    apply_reset();
    configure(2'b01, 16'd0, 16'd0, 8'd0);
    configure(2'b00, 16'd5, 16'd0, 8'd0);
    step(10);
    n_cmp++;
    if (o_lock !== 1'b0 || o_count !== 16'd0 || o_reset !== 1'b0) begin
      n_err++; $display("FAIL idle_bad_cfg: got lock=%0b cnt=%0d rst=%0b expected 0/0/0", o_lock, o_count, o_reset);
    end
    kick(8'h00);
    n_cmp++;
    if (o_reset !== 1'b0 || o_cause !== 2'b00) begin
      n_err++; $display("FAIL idle_kick: got rst=%0b cause=%0d expected 0/0", o_reset, o_cause);
    end
    // rst mid-FIRE
    apply_reset();
    configure(2'b01, 16'd100, 16'd0, 8'd0);
    step(2);
    kick(8'h11);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_cmp++;
    if ({o_reset, o_warn, o_count, o_cause, o_lock, o_fire_cnt} !== 25'd0) begin
      n_err++; $display("FAIL rst_mid_fire: got rst=%0b warn=%0b cnt=%0d cause=%0d lock=%0b fires=%0d expected all 0",
                        o_reset, o_warn, o_count, o_cause, o_lock, o_fire_cnt);
    end
  endtask

  task automatic test_warn_and_saturate();
    apply_reset();
    configure(2'b01, 16'd10, 16'd0, 8'd0);
    step(4);
    n_cmp++;
    if (o_warn !== 1'b0) begin n_err++; $display("FAIL warn_count4: got %0b expected 0", o_warn); end
    step(1);
    n_cmp++;
    if (o_warn !== 1'b1) begin n_err++; $display("FAIL warn_count5: got %0b expected 1", o_warn); end
    kick(8'hA5);
    n_cmp++;
    if (o_warn !== 1'b0) begin n_err++; $display("FAIL warn_after_kick: got %0b expected 0", o_warn); end
    for (int i = 0; i < 16; i++) begin
      kick(8'h00);
      step(4);
      if (i == 14) begin
        n_cmp++;
        if (o_fire_cnt !== 4'd15) begin n_err++; $display("FAIL fire_cnt_15: got %0d expected 15", o_fire_cnt); end
      end
    end
    n_cmp++;
    if (o_fire_cnt !== 4'd15 || o_reset !== 1'b0) begin
      n_err++; $display("FAIL fire_cnt_sat: got fires=%0d rst=%0b expected 15/0", o_fire_cnt, o_reset);
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_window();
    test_bad_key();
    test_pc_stall();
    test_boundary();
    test_warn_and_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finished");
    $fatal(1, "time limit");
  end

endmodule
